// File: rtl/activation_unit_pkg.sv
// Shared definitions for the activation unit: mode and FSM encodings,
// float constants, and the single-precision arithmetic used by the float cores.
// Subnormals are flushed to zero, and results are truncated rather than rounded.
package activation_unit_pkg;

    typedef enum logic [1:0] {ACT_ID = 2'd0, ACT_RELU = 2'd1, ACT_SIG = 2'd2, ACT_TANH = 2'd3} act_e;
    typedef enum logic [2:0] {S_IDLE, S_ADD1, S_DIV, S_ADD2, S_MUL, S_OUT} state_e;

    localparam logic [31:0] FLOAT_ONE  = 32'h3f800000;
    localparam logic [31:0] FLOAT_HALF = 32'h3f000000;
    localparam logic [31:0] FLOAT_QNAN = 32'h7fc00000;

    typedef struct packed {
        logic [31:0] v;
        logic        nan;
        logic        ovf;
        logic        unf;
    } fp_res_t;

    function automatic logic is_nan(input logic [31:0] v);
        return (&v[30:23]) & (|v[22:0]);
    endfunction
    function automatic logic is_inf(input logic [31:0] v);
        return (&v[30:23]) & ~(|v[22:0]);
    endfunction
    function automatic logic is_zero(input logic [31:0] v);
        return ~(|v[30:23]);
    endfunction

    function automatic fp_res_t mk(input logic [31:0] v, input logic n);
        return '{v, n, 1'b0, 1'b0};
    endfunction

    // Saturate to inf / flush to zero when the biased exponent leaves [1,254].
    function automatic fp_res_t fp_pack(input logic s, input int e, input logic [22:0] f);
        if (e >= 255) return '{{s, 8'hff, 23'h0}, 1'b0, 1'b1, 1'b0};
        if (e <= 0)   return '{{s, 31'h0}, 1'b0, 1'b0, 1'b1};
        return '{{s, e[7:0], f}, 1'b0, 1'b0, 1'b0};
    endfunction

    function automatic fp_res_t fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] hi, lo;
        logic [27:0] mh, ml, s;
        int          d, p, e;
        if (is_nan(a) || is_nan(b)) return mk(FLOAT_QNAN, 1'b1);
        if (is_inf(a) && is_inf(b) && (a[31] != b[31])) return mk(FLOAT_QNAN, 1'b1);
        if (is_inf(a)) return mk(a, 1'b0);
        if (is_inf(b)) return mk(b, 1'b0);
        // Order by magnitude so the difference of mantissas is never negative.
        if (a[30:0] >= b[30:0]) begin hi = a; lo = b; end
        else                    begin hi = b; lo = a; end
        if (is_zero(hi)) return mk({hi[31] & lo[31], 31'h0}, 1'b0);
        if (is_zero(lo)) return mk(hi, 1'b0);
        mh = {2'b01, hi[22:0], 3'b000};
        ml = {2'b01, lo[22:0], 3'b000};
        d  = int'(hi[30:23]) - int'(lo[30:23]);
        ml = (d > 27) ? 28'h0 : (ml >> d);
        s  = (hi[31] == lo[31]) ? (mh + ml) : (mh - ml);
        if (s == 28'h0) return mk(32'h0, 1'b0);
        p = 0;
        for (int i = 0; i < 28; i++) if (s[i]) p = i;
        e = int'(hi[30:23]) + p - 26;
        if (p == 27) s = s >> 1;
        else         s = s << (26 - p);
        return fp_pack(hi[31], e, s[25:3]);
    endfunction

    function automatic fp_res_t fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] m;
        int          e;
        s = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b)) return mk(FLOAT_QNAN, 1'b1);
        if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) return mk(FLOAT_QNAN, 1'b1);
        if (is_inf(a) || is_inf(b)) return mk({s, 8'hff, 23'h0}, 1'b0);
        if (is_zero(a) || is_zero(b)) return mk({s, 31'h0}, 1'b0);
        m = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) return fp_pack(s, e + 1, m[46:24]);
        return fp_pack(s, e, m[45:23]);
    endfunction

    function automatic fp_res_t fp_div(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [48:0] q;
        int          e;
        s = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b)) return mk(FLOAT_QNAN, 1'b1);
        if ((is_inf(a) && is_inf(b)) || (is_zero(a) && is_zero(b))) return mk(FLOAT_QNAN, 1'b1);
        if (is_inf(a) || is_zero(b)) return mk({s, 8'hff, 23'h0}, 1'b0);
        if (is_zero(a) || is_inf(b)) return mk({s, 31'h0}, 1'b0);
        // Mantissa ratio lies in (0.5, 2); scaling by 2^25 keeps 24+ significant bits.
        q = {1'b1, a[22:0], 25'h0} / {25'h0, 1'b1, b[22:0]};
        e = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q[25]) return fp_pack(s, e, q[24:2]);
        return fp_pack(s, e - 1, q[23:1]);
    endfunction

endpackage

// File: rtl/activation_unit_fpcores.sv
// Float cores add_float, mul_float, div_float. Common interface:
//   clk_i, rst_ni (async low), start_i (one-cycle pulse), a_i, b_i operands,
//   y_o result, done_o (held high until reset), flags_o = {nan, ovf, unf}.
// Each core produces its result one cycle after start.
module add_float import activation_unit_pkg::*; (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o,
    output logic        done_o,
    output logic [2:0]  flags_o
);
    fp_res_t r_q;
    logic    done_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= '0; done_q <= 1'b0;
        end else if (start_i) begin
            r_q <= fp_add(a_i, b_i); done_q <= 1'b1;
        end
    end
    assign y_o = r_q.v;
    assign done_o = done_q;
    assign flags_o = {r_q.nan, r_q.ovf, r_q.unf};
endmodule

module mul_float import activation_unit_pkg::*; (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o,
    output logic        done_o,
    output logic [2:0]  flags_o
);
    fp_res_t r_q;
    logic    done_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= '0; done_q <= 1'b0;
        end else if (start_i) begin
            r_q <= fp_mul(a_i, b_i); done_q <= 1'b1;
        end
    end
    assign y_o = r_q.v;
    assign done_o = done_q;
    assign flags_o = {r_q.nan, r_q.ovf, r_q.unf};
endmodule

module div_float import activation_unit_pkg::*; (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o,
    output logic        done_o,
    output logic [2:0]  flags_o
);
    fp_res_t r_q;
    logic    done_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= '0; done_q <= 1'b0;
        end else if (start_i) begin
            r_q <= fp_div(a_i, b_i); done_q <= 1'b1;
        end
    end
    assign y_o = r_q.v;
    assign done_o = done_q;
    assign flags_o = {r_q.nan, r_q.ovf, r_q.unf};
endmodule

// File: rtl/activation_unit_lane.sv
// One activation lane: latched input, the four stage cores, stage registers
// and the output mux for identity / relu / sigmoid / tanh.
//   load_i: latch x_i (accept).  state_i: FSM state selecting the active core.
//   start_i: stage start pulse.  cap_i: capture the active core's result.
//   y_o: lane result.  done_o/flags_o: active core's done and {nan,ovf,unf}.
module activation_lane import activation_unit_pkg::*; #(
    parameter int MODE_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [31:0]       x_i,
    input  logic [MODE_W-1:0] mode_i,
    input  state_e            state_i,
    input  logic              start_i,
    input  logic              cap_i,
    output logic [31:0]       y_o,
    output logic              done_o,
    output logic [2:0]        flags_o
);
    logic [31:0] x_q, s1_q, s2_q, s3_q, s4_q;
    logic [31:0] r_add1, r_div, r_add2, r_mul, relu_y;
    logic        d_add1, d_div, d_add2, d_mul;
    logic [2:0]  f_add1, f_div, f_add2, f_mul;
    logic        rst_add1, rst_div, rst_add2, rst_mul;

    // Cores sit in reset outside their own stage so every transaction starts clean.
    assign rst_add1 = rst_ni & (state_i == S_ADD1);
    assign rst_div  = rst_ni & (state_i == S_DIV);
    assign rst_add2 = rst_ni & (state_i == S_ADD2);
    assign rst_mul  = rst_ni & (state_i == S_MUL);

    add_float u_add1 (.clk_i(clk_i), .rst_ni(rst_add1), .start_i(start_i & (state_i == S_ADD1)),
                      .a_i({1'b0, x_q[30:0]}), .b_i(FLOAT_ONE), .y_o(r_add1), .done_o(d_add1), .flags_o(f_add1));
    div_float u_div  (.clk_i(clk_i), .rst_ni(rst_div), .start_i(start_i & (state_i == S_DIV)),
                      .a_i(x_q), .b_i(s1_q), .y_o(r_div), .done_o(d_div), .flags_o(f_div));
    add_float u_add2 (.clk_i(clk_i), .rst_ni(rst_add2), .start_i(start_i & (state_i == S_ADD2)),
                      .a_i(s2_q), .b_i(FLOAT_ONE), .y_o(r_add2), .done_o(d_add2), .flags_o(f_add2));
    mul_float u_mul  (.clk_i(clk_i), .rst_ni(rst_mul), .start_i(start_i & (state_i == S_MUL)),
                      .a_i(s3_q), .b_i(FLOAT_HALF), .y_o(r_mul), .done_o(d_mul), .flags_o(f_mul));

    always_comb begin
        done_o  = 1'b0;
        flags_o = 3'b000;
        case (state_i)
            S_ADD1:  begin done_o = d_add1; flags_o = f_add1; end
            S_DIV:   begin done_o = d_div;  flags_o = f_div;  end
            S_ADD2:  begin done_o = d_add2; flags_o = f_add2; end
            S_MUL:   begin done_o = d_mul;  flags_o = f_mul;  end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0; s1_q <= '0; s2_q <= '0; s3_q <= '0; s4_q <= '0;
        end else begin
            if (load_i) x_q <= x_i;
            if (cap_i) begin
                case (state_i)
                    S_ADD1:  s1_q <= r_add1;
                    S_DIV:   s2_q <= r_div;
                    S_ADD2:  s3_q <= r_add2;
                    S_MUL:   s4_q <= r_mul;
                    default: ;
                endcase
            end
        end
    end

    // NaN passes through relu regardless of its sign; -0 becomes +0.
    assign relu_y = (is_nan(x_q) || !x_q[31]) ? x_q : 32'h0;

    always_comb begin
        case (mode_i)
            ACT_ID:   y_o = x_q;
            ACT_RELU: y_o = relu_y;
            ACT_SIG:  y_o = s4_q;
            default:  y_o = s2_q;
        endcase
    end
endmodule

// File: rtl/activation_unit.sv
// Multi-lane float activation unit (identity, relu, fast sigmoid, fast tanh).
// Ports: clk, rst_n (async low); in_valid/in_ready, mode, x (N packed lanes)
// on the input side; out_valid/out_ready, y, and sticky nan/overflow/underflow
// flags on the output side. Holds the FSM, handshakes, done aggregation and flags.
module activation_unit import activation_unit_pkg::*; #(
    parameter int S      = 32,
    parameter int N      = 4,
    parameter int MODE_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MODE_W-1:0] mode,
    input  logic [S*N-1:0]    x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [S*N-1:0]    y,
    output logic              nan,
    output logic              overflow,
    output logic              underflow
);
    state_e                state_q, state_d;
    logic                  first_q;
    logic [N-1:0]          seen_q, seen_d, lane_done, x_nan;
    logic [N-1:0][2:0]     lane_flags;
    logic [MODE_W-1:0]     mode_q;
    logic [2:0]            flags_q, flags_d;
    logic                  accept, arith, all_done, start;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign accept    = in_valid & in_ready;
    assign arith     = (state_q == S_ADD1) | (state_q == S_DIV) | (state_q == S_ADD2) | (state_q == S_MUL);
    // Lanes may finish on different cycles; a stage ends once every lane has reported.
    assign all_done  = arith & (&(seen_q | lane_done));
    assign start     = first_q & arith;
    assign {nan, overflow, underflow} = flags_q;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign x_nan[i] = is_nan(x[S*i +: S]);
        activation_lane #(.MODE_W(MODE_W)) u_lane (
            .clk_i(clk), .rst_ni(rst_n), .load_i(accept), .x_i(x[S*i +: S]),
            .mode_i(mode_q), .state_i(state_q), .start_i(start), .cap_i(all_done),
            .y_o(y[S*i +: S]), .done_o(lane_done[i]), .flags_o(lane_flags[i])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = (mode == ACT_SIG || mode == ACT_TANH) ? S_ADD1 : S_OUT;
            S_ADD1: if (all_done) state_d = S_DIV;
            S_DIV:  if (all_done) state_d = (mode_q == ACT_TANH) ? S_OUT : S_ADD2;
            S_ADD2: if (all_done) state_d = S_MUL;
            S_MUL:  if (all_done) state_d = S_OUT;
            S_OUT:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        seen_d  = (arith && !all_done) ? (seen_q | lane_done) : '0;
        flags_d = flags_q;
        if (accept) begin
            // Relu is the only pass-through mode that reports NaN inputs.
            flags_d = {(mode == ACT_RELU) & (|x_nan), 2'b00};
        end else if (arith) begin
            for (int i = 0; i < N; i++) if (lane_done[i]) flags_d = flags_d | lane_flags[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            first_q <= 1'b0;
            seen_q  <= '0;
            mode_q  <= '0;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
            seen_q  <= seen_d;
            flags_q <= flags_d;
            if (accept) mode_q <= mode;
        end
    end
endmodule

// File: tb/tb_activation_unit.sv
module tb_activation_unit;
    localparam int S = 32;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [S*N-1:0] x = '0;
    logic          in_ready, out_valid, nan, overflow, underflow;
    logic [S*N-1:0] y;

    int checks = 0;
    int errors = 0;
    int lat, lat_sig, lat_tanh;

    activation_unit #(.S(S), .N(N), .MODE_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .x(x), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .nan(nan), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one transaction; inputs are scrambled after accept to show they are not re-sampled.
    task automatic accept_txn(input logic [1:0] m, input logic [63:0] xv);
        for (int t = 0; t < 50 && !in_ready; t++) step();
        in_valid = 1'b1; mode = m; x = xv;
        step();
        in_valid = 1'b0; mode = 2'd0; x = '1;
    endtask

    // Latency counts clock edges from the accept edge up to the one raising out_valid.
    task automatic run(input logic [1:0] m, input logic [63:0] xv, output int l);
        accept_txn(m, xv);
        l = 1;
        while (!out_valid && l < 200) begin step(); l++; end
        chk("out_valid_seen", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic hs_done(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk(tag, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    function automatic logic [63:0] flg();
        return {61'd0, nan, overflow, underflow};
    endfunction

    initial begin
        repeat (3) step();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_y", y, 64'd0);
        chk("rst_flags", flg(), 64'd0);
        rst_n = 1'b1;
        step();

        // Sigmoid of (1.0, -1.0)
        run(2'd2, 64'h3f800000_bf800000, lat_sig);
        chk("sig_y", y, 64'h3f400000_3e800000);
        chk("sig_flags", flg(), 64'd0);
        chk("sig_lat", 64'(lat_sig), 64'd9);
        hs_done("sig_hs");

        // Tanh of (1.0, -3.0)
        run(2'd3, 64'h3f800000_c0400000, lat_tanh);
        chk("tanh_y", y, 64'h3f000000_bf400000);
        chk("tanh_lat", 64'(lat_tanh), 64'd5);
        chk("tanh_faster", {63'd0, lat_tanh < lat_sig}, 64'd1);
        hs_done("tanh_hs");

        // Relu: negative clamps, positive passes, one cycle after accept
        run(2'd1, 64'hc0000000_40400000, lat);
        chk("relu_y", y, 64'h00000000_40400000);
        chk("relu_lat", 64'(lat), 64'd1);
        chk("relu_flags", flg(), 64'd0);
        hs_done("relu_hs");
        run(2'd1, 64'h40400000_80000000, lat);
        chk("relu_negzero", y, 64'h40400000_00000000);
        hs_done("relu_hs2");
        run(2'd1, 64'hffc00000_3f800000, lat);
        chk("relu_nan_y", y, 64'hffc00000_3f800000);
        chk("relu_nan_flag", flg(), 64'd4);
        hs_done("relu_hs3");

        // Identity passes NaN untouched without flagging
        run(2'd0, 64'hbf800000_7fc00000, lat);
        chk("id_y", y, 64'hbf800000_7fc00000);
        chk("id_flags", flg(), 64'd0);
        chk("id_lat", 64'(lat), 64'd1);
        hs_done("id_hs");

        // Backpressure: hold 20 cycles
        run(2'd2, 64'h3f800000_bf800000, lat);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_y", y, 64'h3f400000_3e800000);
            chk("bp_hs", {62'd0, in_ready, out_valid}, 64'd1);
        end
        hs_done("bp_release");
        run(2'd3, 64'h3f800000_c0400000, lat);
        chk("bp_next_y", y, 64'h3f000000_bf400000);
        hs_done("bp_next_hs");

        // NaN through sigmoid, then a clean transaction clears the flag
        run(2'd2, 64'h3f800000_7fc00000, lat);
        chk("nan_lane1", {32'd0, y[63:32]}, 64'h3f400000);
        chk("nan_lane0_isnan", {63'd0, (&y[30:23]) & (|y[22:0])}, 64'd1);
        chk("nan_flag", flg(), 64'd4);
        hs_done("nan_hs");
        run(2'd2, 64'h3f800000_bf800000, lat);
        chk("nan_clear_flags", flg(), 64'd0);
        chk("nan_clear_y", y, 64'h3f400000_3e800000);
        hs_done("nan_clear_hs");

        // Reset while in the divide stage
        accept_txn(2'd2, 64'h3f800000_bf800000);
        step();
        step();
        chk("div_busy", {62'd0, in_ready, out_valid}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hs", {62'd0, in_ready, out_valid}, 64'd2);
        chk("mid_rst_y", y, 64'd0);
        chk("mid_rst_flags", flg(), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_hs", {62'd0, in_ready, out_valid}, 64'd2);
        run(2'd3, 64'h00000000_3f800000, lat);
        chk("post_rst_y", y, 64'h00000000_3f000000);
        chk("post_rst_flags", flg(), 64'd0);
        hs_done("post_rst_hs2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/activation_unit.md
Name: activation_unit

Overview:
- Parametrised, multi-lane, multi-mode floating-point activation block for the neural-net datapath.
- Sits between a layer's accumulate stage and the next layer's input buffer.
- Computes one of four activations on N IEEE-754 lanes per transaction, using the team's add_float, div_float and mul_float cores.
- Uses a valid/ready handshake on both sides and reports sticky per-transaction exception flags.

Parameters:
- S, 32: float width in bits. Only 32 is supported; the constants are single precision.
- N, 4: lane count, N >= 1.
- MODE_W, 2: width of the mode select.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input vector and mode are valid.
- in_ready  out  1  unit can accept a transaction.
- mode  in  MODE_W  0 = identity, 1 = relu, 2 = fast sigmoid, 3 = fast tanh.
- x  in  S*N  input lanes; lane i is at bits [S*(i+1)-1 : S*i].
- out_valid  out  1  y and flags are valid.
- out_ready  in  1  downstream accepts the result.
- y  out  S*N  result lanes, same packing as x.
- nan  out  1  OR of NaN over all lanes and stages of this transaction.
- overflow  out  1  OR over lanes and stages.
- underflow  out  1  OR over lanes and stages.

Behaviour:
- Reset values: in_ready=1, out_valid=0, y=0, nan=overflow=underflow=0, FSM in IDLE. Every float core is held in reset while rst_n=0.
- Accept: in_valid & in_ready on an edge latches x and mode into registers and leaves IDLE. in_ready=1 only in IDLE; there is no input buffering.
- Functions, with a = |x| formed by clearing the sign bit:
  - tanh: x/(1+a).
  - sigmoid: (x/(1+a) + 1)*0.5.
  - relu: x if the sign bit is 0, else +0. -0 maps to +0; a NaN input passes through and sets nan.
  - identity: x passes through unchanged; flags stay 0.
- States: IDLE, ADD1, DIV, ADD2, MUL, OUT.
  - IDLE -> OUT for modes 0 and 1. y is computed from the latched x, so out_valid rises the cycle after accept.
  - IDLE -> ADD1 for modes 2 and 3.
- Each arithmetic state issues a single-cycle start pulse to all N lane cores of that stage on its first cycle.
  - It then waits until every lane's core done has been seen. Per-lane done bits are latched, because lanes need not finish on the same cycle.
  - It advances on the cycle the last done is seen. Core results are captured into a per-lane stage register at that time.
- Transitions:
  - ADD1 (a + 1.0) -> DIV.
  - DIV (x / opa) -> OUT if mode 3, else ADD2.
  - ADD2 (q + 1.0) -> MUL.
  - MUL (r * 0.5) -> OUT.
- Constants: one = 32'h3f800000, half = 32'h3f000000.
- Core control: each stage's cores receive rst_n & ~clr_stage, where clr_stage is high in every cycle the FSM is not in that stage. Cores therefore start each transaction from reset.
- Flags: cleared on accept. Each core's nan/overflow/underflow is ORed in on its done. div_float divide-by-zero cannot occur (denominator >= 1.0) and is ignored. Flags are held with y until the handshake completes.
- OUT: out_valid=1, y stable. out_valid & out_ready -> IDLE, with in_ready=1 the next cycle. No back-to-back accept in the handshake cycle; minimum issue interval is 2 cycles for modes 0 and 1.
- Backpressure: with out_ready=0, y, flags and out_valid hold indefinitely.
- Timing of mode and x: mode and x are sampled only at accept. Later changes have no effect on the transaction in flight.
- Reset mid-operation: asserting rst_n=0 in any state immediately returns all outputs to their reset values and drops any in-flight result.
- Latency, sigmoid: 1 + Ladd + Ldiv + Ladd + Lmul + 4 cycles from accept to out_valid. Tanh omits the second add and the mul.

Decomposition:
- Shared package (include file `act_defs.v`):
  - mode encodings ACT_ID, ACT_RELU, ACT_SIG, ACT_TANH.
  - FLOAT_ONE and FLOAT_HALF.
  - FSM state encodings.
  - the lane-slice macro.
- One natural sub-module, activation_lane: per-lane core instances (two adds, one div, one mul), relu/identity muxing and stage registers. It is instantiated N times by a generate loop.
- The top level holds the FSM, handshakes, done aggregation and flag ORing.

Test Plan:
- N=2, mode=2, x={3f800000, bf800000} (1.0, -1.0) -> y={3f400000, 3e800000} (0.75, 0.25); flags 0.
- mode=3, x={3f800000, c0400000} (1.0, -3.0) -> y={3f000000, bf400000} (0.5, -0.75); out_valid asserts strictly earlier than for mode 2 on the same input.
- mode=1, x={c0000000, 40400000} (-2.0, 3.0) -> y={00000000, 40400000}; out_valid 1 cycle after accept. Repeat with x lane 0 = 80000000 (-0) -> 00000000.
- mode=2, hold out_ready=0 for 20 cycles after out_valid -> y, out_valid and in_ready=0 are stable. Raise out_ready -> next cycle in_ready=1; a second transaction is accepted with correct result.
- mode=2, x lane 0 = 7fc00000 (NaN) -> y lane 0 is NaN and nan=1; the next transaction with valid input has nan=0.
- Assert rst_n=0 while in DIV for 1 cycle -> out_valid=0, y=0, flags=0, in_ready=1. A new mode=3 transaction with x=3f800000 returns 3f000000.
